xdma_dsc_byp_sched: RTL
=======================

Name: xdma_dsc_byp_sched

Overview:
Schedules descriptors from NUM_REQ user requesters onto the single XDMA channel-0 descriptor bypass interfaces (h2c_dsc_byp_* and c2h_dsc_byp_*).
- Round-robin arbitration across requesters.
- Per-direction output register holds each descriptor until the engine accepts it.
- Per-direction outstanding-descriptor credit counters, retired by completion pulses.
- Sits between the testbench/user logic and the xdma core, clocked by the core's user clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 28, descriptor length width in bytes
MAX_OUTST, 8, max in-flight descriptors per direction (1..15)

Ports:
axi_aclk  in  1  XDMA user clock
axi_areset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  requester i has a descriptor
req_ready  out  NUM_REQ  requester i descriptor consumed this cycle (one-hot or zero)
req_dir  in  NUM_REQ  0 = H2C, 1 = C2H
req_src_addr  in  NUM_REQ*64  packed source addresses
req_dst_addr  in  NUM_REQ*64  packed destination addresses
req_len  in  NUM_REQ*LEN_W  packed byte lengths
req_ctl  in  NUM_REQ*16  packed control fields
h2c_dsc_byp_load / c2h_dsc_byp_load  out  1  descriptor valid to engine
h2c_dsc_byp_ready / c2h_dsc_byp_ready  in  1  engine accepts
h2c_dsc_byp_src_addr, _dst_addr (x2 dirs)  out  64  descriptor addresses
h2c_dsc_byp_len / c2h_dsc_byp_len  out  LEN_W  descriptor length
h2c_dsc_byp_ctl / c2h_dsc_byp_ctl  out  16  descriptor control
h2c_done / c2h_done  in  1  one-cycle pulse per completed descriptor
h2c_outst / c2h_outst  out  4  in-flight descriptor counts
last_grant  out  3  index of the last consumed requester
err_zero_len  out  1  one-cycle pulse when a zero-length descriptor is dropped
err_underflow  out  1  sticky; done pulse received with count 0

Behaviour:
- Reset: all outputs 0, output registers empty, rr_ptr = 0. Assertion mid-transfer drops load immediately; any in-flight descriptor is discarded.
- Engine handshake: a transfer occurs on a cycle with load=1 and ready=1.
  - Fields stay stable while load=1 and ready=0.
  - Load deasserts the cycle after transfer unless a new descriptor was captured the same cycle (back-to-back allowed).
- Direction d is eligible when:
  - its output register is empty or transferring this cycle, and
  - (outst_d + occupied_reg_d) < MAX_OUTST.
- Arbitration: at most one consumption per cycle.
  - Requester i is eligible if req_valid[i]=1 and dir(req_dir[i]) is eligible, or if req_len[i]=0 (zero-length is always consumable).
  - Grant the first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On grant: req_ready[grant]=1 (combinational), last_grant=grant (registered), rr_ptr <= grant+1 mod NUM_REQ.
  - No grant leaves rr_ptr unchanged.
- Zero length: consumed, not issued, err_zero_len pulses next cycle, no credit used.
- Capture: granted fields are registered into the direction's output register; load rises the following cycle. Request-to-load latency is 1 cycle.
- Credits: outst_d increments on a load&ready transfer and decrements on done_d.
  - Simultaneous transfer and done: count unchanged.
  - done_d while outst_d=0: ignored, err_underflow set (cleared only by reset).
- Blocking: an ineligible requester does not block others; round-robin continues past it.
- Length and address fields pass through unmodified; no splitting.

Optional Feature:
DSC_BYP_STATS_EN — when defined, adds outputs h2c_issued_cnt and c2h_issued_cnt (32 bits each).
- Each increments on every transfer in its direction and saturates at 0xFFFFFFFF.
- Both reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 0, H2C, len=0x1000, ready held 1 -> req_ready[0] in cycle 0, h2c load=1 in cycle 1 with src/dst/len matching, h2c_outst=1 in cycle 2.
- Requesters 0..3 all valid, all H2C, ready=1, done never pulsed, MAX_OUTST=8 -> grants 0,1,2,3,0,1,2,3 then stall; h2c_outst=8, req_ready stays 0 until an h2c_done pulse, after which exactly one grant resumes at rr_ptr.
- Requester 1 C2H with c2h ready=0 for 5 cycles -> c2h load=1 with stable fields for all 5 cycles; an H2C request from requester 2 is granted meanwhile.
- Requester 2 len=0 -> consumed, err_zero_len pulses once, no load on either port, outstanding counts unchanged.
- h2c_done on the same cycle as an h2c transfer with outst=3 -> outst stays 3; h2c_done with outst=0 -> err_underflow=1, outst stays 0.
- axi_areset asserted while c2h load=1 -> load=0 immediately, counts 0, rr_ptr=0; after release the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/xdma_dsc_byp_sched.sv
// Round-robin scheduler of NUM_REQ descriptor requesters onto the XDMA H2C/C2H descriptor bypass ports.
// Latency: grant is combinational, load rises 1 cycle after grant; backpressure: per-direction output
// register holds until engine ready, and credit limit MAX_OUTST. Optional DSC_BYP_STATS_EN adds issue counters.
module xdma_dsc_byp_sched #(
    parameter int NUM_REQ   = 4,
    parameter int LEN_W     = 28,
    parameter int MAX_OUTST = 8
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_dir,
    input  logic [NUM_REQ*64-1:0]    req_src_addr,
    input  logic [NUM_REQ*64-1:0]    req_dst_addr,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*16-1:0]    req_ctl,
    output logic                     h2c_dsc_byp_load,
    input  logic                     h2c_dsc_byp_ready,
    output logic [63:0]              h2c_dsc_byp_src_addr,
    output logic [63:0]              h2c_dsc_byp_dst_addr,
    output logic [LEN_W-1:0]         h2c_dsc_byp_len,
    output logic [15:0]              h2c_dsc_byp_ctl,
    output logic                     c2h_dsc_byp_load,
    input  logic                     c2h_dsc_byp_ready,
    output logic [63:0]              c2h_dsc_byp_src_addr,
    output logic [63:0]              c2h_dsc_byp_dst_addr,
    output logic [LEN_W-1:0]         c2h_dsc_byp_len,
    output logic [15:0]              c2h_dsc_byp_ctl,
    input  logic                     h2c_done,
    input  logic                     c2h_done,
    output logic [3:0]               h2c_outst,
    output logic [3:0]               c2h_outst,
    output logic [2:0]               last_grant,
    output logic                     err_zero_len,
    output logic                     err_underflow
`ifdef DSC_BYP_STATS_EN
    ,
    output logic [31:0]              h2c_issued_cnt,
    output logic [31:0]              c2h_issued_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [63:0]      src;
        logic [63:0]      dst;
        logic [LEN_W-1:0] len;
        logic [15:0]      ctl;
    } dsc_t;

    // Index 0 is H2C, index 1 is C2H throughout.
    dsc_t             dsc_q [2];
    logic [3:0]       outst_q [2];
    logic [1:0]       load_q;
    logic [1:0]       byp_rdy;
    logic [1:0]       done_in;
    logic [1:0]       xfer;
    logic [1:0]       dir_elig;
    logic [1:0]       capture;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_nxt;
    logic [IDX_W-1:0] grant_idx;
    logic [2:0]       last_grant_q;
    logic             zlen_pulse_q;
    logic             underflow_q;
    logic [NUM_REQ-1:0] zlen;
    logic [NUM_REQ-1:0] req_elig;
    logic             grant_vld;
    logic             gnt_dir;
    logic             gnt_zlen;
    dsc_t             gnt_dsc;

    assign byp_rdy = {c2h_dsc_byp_ready, h2c_dsc_byp_ready};
    assign done_in = {c2h_done, h2c_done};
    assign xfer    = load_q & byp_rdy;

    // A held descriptor already counts against the credit budget.
    always_comb begin
        dir_elig = '0;
        for (int d = 0; d < 2; d++) begin
            dir_elig[d] = (!load_q[d] || byp_rdy[d]) &&
                          ((5'(outst_q[d]) + 5'(load_q[d])) < 5'(MAX_OUTST));
        end
    end

    always_comb begin
        zlen     = '0;
        req_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            zlen[i]     = (req_len[i*LEN_W +: LEN_W] == '0);
            req_elig[i] = req_valid[i] && (zlen[i] || dir_elig[req_dir[i]]);
        end
    end

    // Two passes give the circular scan starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_elig[i] && (IDX_W'(i) >= rr_ptr)) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_elig[i] && (IDX_W'(i) < rr_ptr)) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        if (axi_areset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        gnt_dsc   = '0;
        gnt_dir   = 1'b0;
        gnt_zlen  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                gnt_dsc.src  = req_src_addr[i*64 +: 64];
                gnt_dsc.dst  = req_dst_addr[i*64 +: 64];
                gnt_dsc.len  = req_len[i*LEN_W +: LEN_W];
                gnt_dsc.ctl  = req_ctl[i*16 +: 16];
                gnt_dir      = req_dir[i];
                gnt_zlen     = zlen[i];
                req_ready[i] = grant_vld;
            end
        end
    end

    assign capture[0] = grant_vld && !gnt_zlen && !gnt_dir;
    assign capture[1] = grant_vld && !gnt_zlen && gnt_dir;
    assign rr_nxt     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            rr_ptr       <= '0;
            last_grant_q <= '0;
            zlen_pulse_q <= 1'b0;
            underflow_q  <= 1'b0;
            load_q       <= '0;
            for (int d = 0; d < 2; d++) begin
                dsc_q[d]   <= '0;
                outst_q[d] <= '0;
            end
        end else begin
            zlen_pulse_q <= grant_vld && gnt_zlen;
            if (grant_vld) begin
                rr_ptr       <= rr_nxt;
                last_grant_q <= 3'(grant_idx);
            end
            for (int d = 0; d < 2; d++) begin
                if (capture[d]) begin
                    dsc_q[d]  <= gnt_dsc;
                    load_q[d] <= 1'b1;
                end else if (xfer[d]) begin
                    load_q[d] <= 1'b0;
                end
                // A completion with nothing in flight is dropped and flagged.
                if (done_in[d] && (outst_q[d] == 4'd0)) begin
                    underflow_q <= 1'b1;
                    outst_q[d]  <= outst_q[d] + 4'(xfer[d]);
                end else begin
                    outst_q[d]  <= outst_q[d] + 4'(xfer[d]) - 4'(done_in[d]);
                end
            end
        end
    end

`ifdef DSC_BYP_STATS_EN
    logic [31:0] issued_q [2];

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            issued_q[0] <= '0;
            issued_q[1] <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (xfer[d] && (issued_q[d] != 32'hFFFF_FFFF)) begin
                    issued_q[d] <= issued_q[d] + 32'd1;
                end
            end
        end
    end

    assign h2c_issued_cnt = issued_q[0];
    assign c2h_issued_cnt = issued_q[1];
`endif

    assign h2c_dsc_byp_load     = load_q[0];
    assign h2c_dsc_byp_src_addr = dsc_q[0].src;
    assign h2c_dsc_byp_dst_addr = dsc_q[0].dst;
    assign h2c_dsc_byp_len      = dsc_q[0].len;
    assign h2c_dsc_byp_ctl      = dsc_q[0].ctl;
    assign c2h_dsc_byp_load     = load_q[1];
    assign c2h_dsc_byp_src_addr = dsc_q[1].src;
    assign c2h_dsc_byp_dst_addr = dsc_q[1].dst;
    assign c2h_dsc_byp_len      = dsc_q[1].len;
    assign c2h_dsc_byp_ctl      = dsc_q[1].ctl;
    assign h2c_outst            = outst_q[0];
    assign c2h_outst            = outst_q[1];
    assign last_grant           = last_grant_q;
    assign err_zero_len         = zlen_pulse_q;
    assign err_underflow        = underflow_q;

endmodule
